// File: rtl/evt_wd_pkg.sv
// Shared types and helpers for the event watchdog: the watch-mode and
// channel-state encodings plus a width helper for channel indices.
package evt_wd_pkg;

  // How a channel decides that its awaited event has happened.
  typedef enum logic [1:0] {
    EVT_RISE  = 2'b00,
    EVT_LEVEL = 2'b01,
    EVT_FALL  = 2'b10,
    EVT_COUNT = 2'b11
  } evt_mode_e;

  // Per-channel lifecycle.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    PASS = 2'b10,
    FAIL = 2'b11
  } chan_state_e;

  // Width needed to hold a channel index; never narrower than one bit so a
  // single-channel build still has a legal first_tmo port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/evt_watchdog_if.sv
// Control/status bundle between a watchdog user (master) and the
// watchdog itself (slave). Clock and reset travel as plain ports.
interface evt_watchdog_if
  import evt_wd_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TW  = 20,
  parameter int CW  = 8
) ();

  localparam int FW = idx_width(NCH);

  // Requests towards the watchdog
  logic [NCH-1:0]    arm;
  logic [NCH-1:0]    abort;
  logic [2*NCH-1:0]  mode;
  logic [TW*NCH-1:0] limit;
  logic [CW*NCH-1:0] target;
  logic [NCH-1:0]    evt;
  logic              clr_err;

  // Status from the watchdog
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    tmo;
  logic              any_tmo;
  logic [FW-1:0]     first_tmo;
  logic              all_done;

  modport master (
    output arm, abort, mode, limit, target, evt, clr_err,
    input  busy, done, tmo, any_tmo, first_tmo, all_done
  );

  modport slave (
    input  arm, abort, mode, limit, target, evt, clr_err,
    output busy, done, tmo, any_tmo, first_tmo, all_done
  );

endinterface

// File: rtl/evt_wd_chan.sv
// One watchdog channel: captures mode/limit/target on arm, then waits for
// its qualifying event within a cycle budget and ends in PASS or FAIL.
module evt_wd_chan
  import evt_wd_pkg::*;
#(
  parameter int TW = 20,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [TW-1:0] limit,
  input  logic [CW-1:0] target,
  input  logic          evt,
  output logic          busy,
  output logic          done,
  output logic          tmo,
  output logic          fail_set,   // this edge takes WAIT -> FAIL
  output logic          done_next   // value done takes after this edge
);

  chan_state_e   state_reg;
  evt_mode_e     mode_reg;
  logic [TW-1:0] limit_reg;
  logic [CW-1:0] target_reg;
  logic [TW-1:0] cyc_reg;
  logic [CW-1:0] edge_reg;
  logic          evt_q_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          tmo_reg;

  logic          rise;
  logic          fall;
  logic [CW-1:0] edge_inc;
  logic          qualify;
  logic          expire;
  logic          eval;
  logic          pass_set;

  // Decide what the current evaluation edge means for this channel.
  always_comb begin
    rise     = evt & ~evt_q_reg;
    fall     = ~evt & evt_q_reg;
    // Saturating edge count so a huge pulse train cannot wrap back to 0.
    edge_inc = (edge_reg == '1) ? edge_reg : edge_reg + CW'(1);
    qualify  = 1'b0;
    case (mode_reg)
      EVT_RISE:  qualify = rise;
      EVT_LEVEL: qualify = evt;
      EVT_FALL:  qualify = fall;
      EVT_COUNT: qualify = (target_reg == '0) || (rise && (edge_inc == target_reg));
      default:   qualify = 1'b0;
    endcase
    expire    = (cyc_reg == limit_reg);
    // abort and arm take precedence over any evaluation on the same edge
    eval      = (state_reg == WAIT) && !abort && !arm;
    // event beats expiry when both land on one edge
    pass_set  = eval && qualify;
    fail_set  = eval && !qualify && expire;
    done_next = !abort && !arm && (pass_set || done_reg);
  end

  // Channel FSM with counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mode_reg   <= EVT_RISE;
      limit_reg  <= '0;
      target_reg <= '0;
      cyc_reg    <= '0;
      edge_reg   <= '0;
      evt_q_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      tmo_reg    <= 1'b0;
    end else begin
      // Tracking evt every cycle means an arm edge loads the current level,
      // so history from before the arm never looks like a fresh edge.
      evt_q_reg <= evt;
      if (abort) begin
        state_reg <= IDLE;
        cyc_reg   <= '0;
        edge_reg  <= '0;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b0;
        tmo_reg   <= 1'b0;
      end else if (arm) begin
        state_reg  <= WAIT;
        mode_reg   <= evt_mode_e'(mode);
        limit_reg  <= limit;
        target_reg <= target;
        cyc_reg    <= '0;
        edge_reg   <= '0;
        busy_reg   <= 1'b1;
        done_reg   <= 1'b0;
        tmo_reg    <= 1'b0;
      end else if (state_reg == WAIT) begin
        if (qualify) begin
          state_reg <= PASS;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end else if (expire) begin
          state_reg <= FAIL;
          busy_reg  <= 1'b0;
          tmo_reg   <= 1'b1;
        end else begin
          // cyc_reg stops at limit_reg, so it can never wrap
          cyc_reg <= cyc_reg + TW'(1);
          if (rise) begin
            edge_reg <= edge_inc;
          end
        end
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign tmo  = tmo_reg;

endmodule

// File: rtl/evt_watchdog.sv
// Multi-channel event watchdog: NCH independent channels plus shared
// timeout bookkeeping (any_tmo / first_tmo) and an all-passed flag.
module evt_watchdog
  import evt_wd_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TW  = 20,
  parameter int CW  = 8
) (
  input logic           clk,
  input logic           rst,
  evt_watchdog_if.slave bus
);

  localparam int FW = idx_width(NCH);

  logic [NCH-1:0] busy_w;
  logic [NCH-1:0] done_w;
  logic [NCH-1:0] tmo_w;
  logic [NCH-1:0] fail_set_w;
  logic [NCH-1:0] done_next_w;

  logic [FW-1:0]  fail_idx;
  logic           any_tmo_reg;
  logic [FW-1:0]  first_tmo_reg;
  logic           all_done_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      evt_wd_chan #(
        .TW(TW),
        .CW(CW)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .arm      (bus.arm[gi]),
        .abort    (bus.abort[gi]),
        .mode     (bus.mode[2*gi +: 2]),
        .limit    (bus.limit[TW*gi +: TW]),
        .target   (bus.target[CW*gi +: CW]),
        .evt      (bus.evt[gi]),
        .busy     (busy_w[gi]),
        .done     (done_w[gi]),
        .tmo      (tmo_w[gi]),
        .fail_set (fail_set_w[gi]),
        .done_next(done_next_w[gi])
      );
    end
  endgenerate

  // Lowest-numbered channel timing out on this edge.
  always_comb begin
    fail_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (fail_set_w[i]) begin
        fail_idx = FW'(i);
      end
    end
  end

  // Sticky timeout summary; a fresh timeout outranks a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_tmo_reg   <= 1'b0;
      first_tmo_reg <= '0;
      all_done_reg  <= 1'b0;
    end else begin
      if (|fail_set_w) begin
        if (!any_tmo_reg || bus.clr_err) begin
          first_tmo_reg <= fail_idx;
        end
        any_tmo_reg <= 1'b1;
      end else if (bus.clr_err) begin
        any_tmo_reg   <= 1'b0;
        first_tmo_reg <= '0;
      end
      // Registered from next-state done so it moves on the same edge.
      all_done_reg <= &done_next_w;
    end
  end

  assign bus.busy      = busy_w;
  assign bus.done      = done_w;
  assign bus.tmo       = tmo_w;
  assign bus.any_tmo   = any_tmo_reg;
  assign bus.first_tmo = first_tmo_reg;
  assign bus.all_done  = all_done_reg;

endmodule

// File: tb/tb_evt_watchdog.sv
// Self-checking bench for evt_watchdog: directed scenarios followed by
// randomized traffic, all compared each cycle against a behavioural model.
module tb_evt_watchdog;
  import evt_wd_pkg::*;

  localparam int NCH = 4;
  localparam int TW  = 20;
  localparam int CW  = 8;
  localparam int FW  = idx_width(NCH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  evt_watchdog_if #(.NCH(NCH), .TW(TW), .CW(CW)) bus ();

  evt_watchdog #(.NCH(NCH), .TW(TW), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase 0 idle, 1 watching, 2 passed, 3 timed out.
  int m_phase [NCH];
  int m_evals [NCH];   // evaluation edges seen since arm
  int m_edges [NCH];   // rising edges seen since arm (saturating)
  int m_mode  [NCH];
  int m_lim   [NCH];
  int m_tg    [NCH];
  bit m_prev  [NCH];
  bit m_any;
  int m_first;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_phase[c] = 0; m_evals[c] = 0; m_edges[c] = 0;
      m_mode[c] = 0; m_lim[c] = 0; m_tg[c] = 0; m_prev[c] = 0;
    end
    m_any = 0;
    m_first = 0;
  endtask

  // Apply the rules to the inputs present at this clock edge.
  task automatic model_step();
    int  lo;
    bit  e, rise, fall, q;
    lo = -1;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      e    = bus.evt[c];
      rise = e && !m_prev[c];
      fall = !e && m_prev[c];
      if (bus.abort[c]) begin
        m_phase[c] = 0;
      end else if (bus.arm[c]) begin
        m_phase[c] = 1; m_evals[c] = 0; m_edges[c] = 0;
        m_mode[c] = int'(bus.mode[2*c +: 2]);
        m_lim[c]  = int'(bus.limit[TW*c +: TW]);
        m_tg[c]   = int'(bus.target[CW*c +: CW]);
      end else if (m_phase[c] == 1) begin
        m_evals[c]++;
        if (rise && m_edges[c] < 255) m_edges[c]++;
        case (m_mode[c])
          0: q = rise;
          1: q = e;
          2: q = fall;
          default: q = (m_tg[c] == 0) || (rise && m_edges[c] == m_tg[c]);
        endcase
        if (q) begin
          m_phase[c] = 2;
        end else if (m_evals[c] - 1 == m_lim[c]) begin
          m_phase[c] = 3;
          if (lo < 0) lo = c;
        end
      end
      m_prev[c] = e;
    end
    if (lo >= 0) begin
      if (!m_any || bus.clr_err) m_first = lo;
      m_any = 1;
    end else if (bus.clr_err) begin
      m_any = 0;
      m_first = 0;
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] eb, ed, et;
    bit all_p;
    all_p = 1;
    for (int c = 0; c < NCH; c++) begin
      eb[c] = (m_phase[c] == 1);
      ed[c] = (m_phase[c] == 2);
      et[c] = (m_phase[c] == 3);
      if (m_phase[c] != 2) all_p = 0;
    end
    chk("busy", 64'(bus.busy), 64'(eb));
    chk("done", 64'(bus.done), 64'(ed));
    chk("tmo", 64'(bus.tmo), 64'(et));
    chk("any_tmo", 64'(bus.any_tmo), 64'(m_any));
    chk("first_tmo", 64'(bus.first_tmo), 64'(m_first));
    chk("all_done", 64'(bus.all_done), 64'(all_p));
  endtask

  // One clock: model sees the same inputs as the DUT, outputs checked 1ns
  // later, then single-cycle pulses are dropped.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    bus.arm     = '0;
    bus.abort   = '0;
    bus.clr_err = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic set_ch(input int c, input int md, input int lim, input int tg);
    bus.mode[2*c +: 2]    = 2'(md);
    bus.limit[TW*c +: TW] = TW'(lim);
    bus.target[CW*c +: CW] = CW'(tg);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    model_reset();
    bus.arm = '0; bus.abort = '0; bus.mode = '0; bus.limit = '0;
    bus.target = '0; bus.evt = '0; bus.clr_err = 1'b0;
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_all_done", 64'(bus.all_done), 0);
    $display("[%0t] reset done", $time);

    // Rising edge at evaluation 40 within a 100-cycle budget.
    set_ch(0, 0, 100, 0);
    bus.arm[0] = 1'b1;
    tick();
    repeat (39) tick();
    bus.evt[0] = 1'b1;
    tick();
    chk("r35_done0", 64'(bus.done[0]), 1);
    chk("r35_busy0", 64'(bus.busy[0]), 0);
    chk("r35_tmo0", 64'(bus.tmo[0]), 0);
    chk("r35_any", 64'(bus.any_tmo), 0);
    bus.evt[0] = 1'b0;
    $display("[%0t] ch0 rising-edge pass", $time);

    // Level mode with evt held low: times out on the 4th evaluation.
    set_ch(2, 1, 3, 0);
    bus.arm[2] = 1'b1;
    tick();
    repeat (3) tick();
    chk("r36_not_yet", 64'(bus.tmo[2]), 0);
    tick();
    chk("r36_tmo2", 64'(bus.tmo[2]), 1);
    chk("r36_any", 64'(bus.any_tmo), 1);
    chk("r36_first", 64'(bus.first_tmo), 2);
    $display("[%0t] ch2 level timeout", $time);

    // Edge count: 5 pulses pass, 4 pulses run out the budget.
    set_ch(1, 3, 1000, 5);
    bus.arm[1] = 1'b1;
    tick();
    repeat (5) begin
      bus.evt[1] = 1'b1; tick();
      bus.evt[1] = 1'b0; tick();
    end
    chk("r37_done1", 64'(bus.done[1]), 1);
    bus.arm[1] = 1'b1;
    tick();
    repeat (4) begin
      bus.evt[1] = 1'b1; tick();
      bus.evt[1] = 1'b0; tick();
    end
    k = 0;
    while (!bus.tmo[1] && k < 1100) begin
      tick();
      k++;
    end
    chk("r37_tmo1", 64'(bus.tmo[1]), 1);
    chk("r37_fail_edge", 64'(8 + k), 1001);
    $display("[%0t] ch1 edge-count pass then timeout", $time);

    // Two simultaneous timeouts; lowest index recorded, clr_err keeps flags.
    bus.clr_err = 1'b1;
    tick();
    set_ch(1, 1, 10, 0);
    set_ch(3, 1, 10, 0);
    bus.arm = 4'b1010;
    tick();
    repeat (10) tick();
    chk("r38_before", 64'(bus.tmo & 4'b1010), 0);
    tick();
    chk("r38_tmo13", 64'(bus.tmo & 4'b1010), 64'(4'b1010));
    chk("r38_first", 64'(bus.first_tmo), 1);
    bus.clr_err = 1'b1;
    tick();
    chk("r38_any_clr", 64'(bus.any_tmo), 0);
    chk("r38_first_clr", 64'(bus.first_tmo), 0);
    chk("r38_tmo_kept", 64'(bus.tmo & 4'b1010), 64'(4'b1010));
    $display("[%0t] ch1/ch3 simultaneous timeout", $time);

    // Event on the expiry edge wins; then abort beats arm.
    set_ch(0, 0, 5, 0);
    bus.arm[0] = 1'b1;
    tick();
    repeat (5) tick();
    bus.evt[0] = 1'b1;
    tick();
    chk("r39_done0", 64'(bus.done[0]), 1);
    chk("r39_tmo0", 64'(bus.tmo[0]), 0);
    bus.abort[0] = 1'b1;
    bus.arm[0] = 1'b1;
    tick();
    chk("r39_abort", 64'({bus.busy[0], bus.done[0], bus.tmo[0]}), 0);
    bus.evt[0] = 1'b0;

    // clr_err coinciding with a new timeout keeps the new one.
    set_ch(2, 1, 0, 0);
    bus.arm[2] = 1'b1;
    tick();
    bus.clr_err = 1'b1;
    tick();
    chk("clr_vs_new_any", 64'(bus.any_tmo), 1);
    chk("clr_vs_new_first", 64'(bus.first_tmo), 2);
    $display("[%0t] coincident expiry, abort and clr_err cases", $time);

    // Reset mid-watch, then all_done only once every channel passes.
    for (int c = 0; c < NCH; c++) set_ch(c, 1, 50, 0);
    bus.evt = '0;
    bus.arm = '1;
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("r40_rst_flags", 64'({bus.busy, bus.done, bus.tmo}), 0);
    chk("r40_rst_any", 64'(bus.any_tmo), 0);
    bus.arm = '1;
    tick();
    bus.evt = 4'b0111;
    tick();
    chk("r40_partial", 64'(bus.all_done), 0);
    bus.evt = 4'b1111;
    tick();
    chk("r40_all_done", 64'(bus.all_done), 1);
    bus.evt = '0;
    $display("[%0t] reset mid-watch and all_done", $time);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.evt = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        set_ch(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
               int'($urandom_range(0, 3)));
        bus.arm[c]   = ($urandom_range(0, 7) == 0);
        bus.abort[c] = ($urandom_range(0, 15) == 0);
      end
      bus.clr_err = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    $display("[%0t] random traffic complete", $time);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/evt_watchdog.md
EVT_WATCHDOG -- requirements
Module: evt_watchdog

Interface
REQ-001 Parameter NCH, default 4, number of independent watched channels (1..16).
REQ-002 Parameter TW, default 20, width of per-channel cycle budget.
REQ-003 Parameter CW, default 8, width of per-channel edge-count target.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 arm  in  NCH  per-channel start pulse; mode/limit/target captured on the arming edge.
REQ-007 abort  in  NCH  per-channel cancel pulse.
REQ-008 mode  in  2*NCH  per-channel mode: 00 rising edge, 01 level high, 10 falling edge, 11 edge count.
REQ-009 limit  in  TW*NCH  per-channel cycle budget.
REQ-010 target  in  CW*NCH  per-channel rising-edge count (mode 11 only).
REQ-011 evt  in  NCH  watched event, already synchronous to clk.
REQ-012 clr_err  in  1  clears any_tmo and first_tmo.
REQ-013 busy  out  NCH  channel waiting.
REQ-014 done  out  NCH  sticky pass flag.
REQ-015 tmo  out  NCH  sticky timeout flag.
REQ-016 any_tmo  out  1  sticky OR of timeouts since rst/clr_err.
REQ-017 first_tmo  out  $clog2(NCH) (min 1)  index of first channel to time out.
REQ-018 all_done  out  1  AND of done over all channels.

Function
REQ-019 Each channel SHALL run FSM IDLE -> WAIT -> PASS | FAIL; busy=1 only in WAIT, done=1 only in PASS, tmo=1 only in FAIL.
REQ-020 arm sampled at edge k SHALL place channel in WAIT after edge k with cycle counter=0, edge counter=0, done/tmo cleared, and evt_q loaded with current evt (no false edge from pre-arm history).
REQ-021 At each edge in WAIT: qualifying event -> PASS; else if cycle counter == captured limit -> FAIL; else cycle counter +1.
REQ-022 Qualifying event: mode 00 evt&~evt_q; 01 evt; 10 ~evt&evt_q; 11 rising edge making edge count reach captured target.
REQ-023 Event and budget expiry on the same edge SHALL resolve to PASS.
REQ-024 limit=0 SHALL give exactly one evaluation edge; target=0 in mode 11 SHALL pass on the first evaluation edge.
REQ-025 Edge counter SHALL saturate at all-ones; cycle counter SHALL never wrap (FAIL reached first).
REQ-026 arm in WAIT, PASS or FAIL SHALL restart per REQ-020; arm in IDLE starts normally.
REQ-027 abort SHALL return the channel to IDLE with busy/done/tmo cleared; abort and arm on the same edge -> abort wins.
REQ-028 any_tmo SHALL set on any WAIT->FAIL transition; first_tmo SHALL latch that channel's index only when any_tmo was 0; simultaneous timeouts -> lowest index.
REQ-029 clr_err SHALL clear any_tmo and first_tmo; clr_err with a new timeout on the same edge -> new timeout recorded.
REQ-030 All outputs SHALL be registered; flags change on the edge after the deciding evaluation, no combinational input-to-output paths.

Reset
REQ-031 rst SHALL force all channels IDLE, all counters and evt_q to 0, busy=done=tmo=0, any_tmo=0, first_tmo=0, all_done=0 (NCH>=1).
REQ-032 rst SHALL override arm, abort and clr_err on the same edge; mid-WAIT reset discards the pending watch.

Structure
REQ-033 Package evt_wd_pkg SHALL hold the mode enum (EVT_RISE, EVT_LEVEL, EVT_FALL, EVT_COUNT) and state enum (IDLE, WAIT, PASS, FAIL).
REQ-034 Sub-module evt_wd_chan SHALL implement one channel (FSM, counters, edge detect), instantiated NCH times by generate; top holds aggregation and first_tmo logic.

Verification
REQ-035 Arm ch0 mode 00 limit=100, rising evt at cycle 40 -> done[0]=1 one edge later, busy[0]=0, tmo[0]=0, any_tmo=0.
REQ-036 Arm ch2 mode 01 limit=3, evt held 0 -> tmo[2]=1 after edge 4 post-arm, any_tmo=1, first_tmo=2.
REQ-037 Arm ch1 mode 11 target=5 limit=1000, 5 evt pulses -> done[1] on 5th rising edge; 4 pulses only -> tmo[1] at budget expiry.
REQ-038 Arm ch1 and ch3 limit=10 simultaneously, no events -> both tmo on same edge, first_tmo=1; clr_err -> any_tmo=0, tmo flags remain.
REQ-039 Event coincident with expiry edge (limit=5, evt rises on 6th evaluation) -> PASS; abort+arm same edge -> IDLE.
REQ-040 rst asserted mid-WAIT on all channels -> all outputs 0 next edge; all_done=1 only after every channel passes.
